// File: rtl/syzygy_adc_capture_ctrl.sv
// Capture controller for SYZYGY serial-LVDS ADCs: SERDES reset sequencing, bitslip frame
// training with a slip limit, lock-loss monitoring and per-channel sample formatting.
module syzygy_adc_capture_ctrl #(
  parameter int                 NUM_CH            = 2,
  parameter int                 ADC_BITS          = 14,
  parameter int                 FR_BITS           = 8,
  parameter logic [FR_BITS-1:0] FR_PATTERN        = 8'hF0,
  parameter int                 SERDES_RST_CYCLES = 16,
  parameter int                 BITSLIP_WAIT      = 4,
  parameter int                 MAX_SLIPS         = 8,
  parameter int                 LOCK_LOSS_COUNT   = 4
) (
  input  logic                       adc_data_clk,
  input  logic                       reset_async,
  input  logic                       train_start,
  input  logic                       fmt_twos,
  input  logic [FR_BITS-1:0]         frame_word,
  input  logic [NUM_CH*ADC_BITS-1:0] ch_word,
  output logic                       serdes_reset,
  output logic                       bitslip,
  output logic                       aligned,
  output logic                       align_error,
  output logic [3:0]                 slip_count,
  output logic                       data_valid,
  output logic [NUM_CH*16-1:0]       adc_data,
  output logic [31:0]                sample_count
);

  localparam logic [2:0] ST_RESET_SERDES = 3'd0;
  localparam logic [2:0] ST_SETTLE       = 3'd1;
  localparam logic [2:0] ST_CHECK        = 3'd2;
  localparam logic [2:0] ST_SLIP         = 3'd3;
  localparam logic [2:0] ST_LOCKED       = 3'd4;
  localparam logic [2:0] ST_FAIL         = 3'd5;

  localparam int CNT_MAX = (SERDES_RST_CYCLES > BITSLIP_WAIT) ? SERDES_RST_CYCLES : BITSLIP_WAIT;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int MW      = $clog2(LOCK_LOSS_COUNT + 1);

  localparam logic [CW-1:0] RST_LOAD  = CW'(SERDES_RST_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(BITSLIP_WAIT - 1);
  localparam logic [MW-1:0] MISS_MAX  = MW'(LOCK_LOSS_COUNT);
  localparam logic [3:0]    SLIP_MAX  = 4'(MAX_SLIPS);

  logic [2:0]               state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [3:0]               slip_q, slip_d;
  logic [MW-1:0]            miss_q, miss_d, miss_inc;
  logic                     dv_q, dv_d;
  logic [NUM_CH*16-1:0]     adc_q, adc_d;
  logic [31:0]              sc_q, sc_d;
  logic                     frame_match;
  logic                     enter_rst;

  assign frame_match = (frame_word == FR_PATTERN);
  assign miss_inc    = miss_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slip_d  = slip_q;
    miss_d  = miss_q;
    unique case (state_q)
      ST_RESET_SERDES: begin
        if (cnt_q == '0) begin
          state_d = ST_SETTLE;
          cnt_d   = WAIT_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_CHECK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_CHECK: begin
        if (frame_match)             state_d = ST_LOCKED;
        else if (slip_q == SLIP_MAX) state_d = ST_FAIL;
        else                         state_d = ST_SLIP;
      end
      ST_SLIP: begin
        slip_d  = slip_q + 4'd1;
        state_d = ST_SETTLE;
        cnt_d   = WAIT_LOAD;
      end
      ST_LOCKED: begin
        if (frame_match)               miss_d  = '0;
        else if (miss_inc == MISS_MAX) state_d = ST_RESET_SERDES;
        else                           miss_d  = miss_inc;
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_RESET_SERDES;
    endcase
    if (train_start) state_d = ST_RESET_SERDES;

    // Any entry into RESET_SERDES (including a re-request while already there) restarts training.
    enter_rst = train_start || (state_d == ST_RESET_SERDES && state_q != ST_RESET_SERDES);
    if (enter_rst) begin
      cnt_d  = RST_LOAD;
      slip_d = '0;
      miss_d = '0;
    end
  end

  function automatic logic [15:0] fmt_sample(input logic [ADC_BITS-1:0] raw, input logic twos);
    logic signed [ADC_BITS-1:0] flipped;
    logic [15:0]                res;
    flipped = {~raw[ADC_BITS-1], raw[ADC_BITS-2:0]};
    if (twos) res = 16'(flipped);
    else      res = 16'(raw);
    return res;
  endfunction

  always_comb begin
    adc_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      adc_d[c*16 +: 16] = fmt_sample(ch_word[c*ADC_BITS +: ADC_BITS], fmt_twos);
    end
    dv_d = (state_q == ST_LOCKED) && frame_match;
    sc_d = sc_q;
    // Count the valid word currently presented; only while still locked so a stale strobe
    // from the edge that left LOCKED cannot leak into the next run.
    if (enter_rst)                                                sc_d = '0;
    else if (dv_q && state_q == ST_LOCKED && sc_q != 32'hFFFF_FFFF) sc_d = sc_q + 32'd1;
  end

  always_ff @(posedge adc_data_clk or posedge reset_async) begin
    if (reset_async) begin
      state_q <= ST_RESET_SERDES;
      cnt_q   <= RST_LOAD;
      slip_q  <= '0;
      miss_q  <= '0;
      dv_q    <= 1'b0;
      adc_q   <= '0;
      sc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slip_q  <= slip_d;
      miss_q  <= miss_d;
      dv_q    <= dv_d;
      adc_q   <= adc_d;
      sc_q    <= sc_d;
    end
  end

  assign serdes_reset = (state_q == ST_RESET_SERDES);
  assign bitslip      = (state_q == ST_SLIP);
  assign aligned      = (state_q == ST_LOCKED);
  assign align_error  = (state_q == ST_FAIL);
  assign slip_count   = slip_q;
  assign data_valid   = dv_q;
  assign adc_data     = adc_q;
  assign sample_count = sc_q;

endmodule

// File: tb/tb_syzygy_adc_capture_ctrl.sv
// Directed bench for syzygy_adc_capture_ctrl at default parameters: training, slips, failure,
// lock loss, formatting table and asynchronous reset.
module tb_syzygy_adc_capture_ctrl;

  localparam logic [7:0] FR = 8'hF0;

  logic        adc_data_clk = 1'b0;
  logic        reset_async;
  logic        train_start;
  logic        fmt_twos;
  logic [7:0]  frame_word;
  logic [27:0] ch_word;
  logic        serdes_reset, bitslip, aligned, align_error, data_valid;
  logic [3:0]  slip_count;
  logic [31:0] adc_data;
  logic [31:0] sample_count;

  int errors = 0;
  int checks = 0;
  bit model_en = 1'b0;
  int model_slips = 0;

  syzygy_adc_capture_ctrl dut (
    .adc_data_clk (adc_data_clk),
    .reset_async  (reset_async),
    .train_start  (train_start),
    .fmt_twos     (fmt_twos),
    .frame_word   (frame_word),
    .ch_word      (ch_word),
    .serdes_reset (serdes_reset),
    .bitslip      (bitslip),
    .aligned      (aligned),
    .align_error  (align_error),
    .slip_count   (slip_count),
    .data_valid   (data_valid),
    .adc_data     (adc_data),
    .sample_count (sample_count)
  );

  always #5 adc_data_clk = ~adc_data_clk;

  typedef struct {
    logic        twos;
    logic [13:0] c0;
    logic [13:0] c1;
    logic [31:0] exp;
  } fmt_vec_t;

  fmt_vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // Deserialiser model: each bitslip rotates the frame one bit, aligned after three slips.
  task automatic tick();
    @(posedge adc_data_clk);
    #1;
    if (model_en) begin
      if (bitslip) model_slips++;
      frame_word = rotl(FR, (3 - model_slips) & 7);
    end
  endtask

  task automatic pulse_train();
    train_start = 1'b1;
    tick();
    train_start = 1'b0;
  endtask

  task automatic train_watch(input int limit, output int rst_cyc, output int pulses,
                             output int lock_edge, output int err_edge, output int gap_bad);
    int last;
    rst_cyc = serdes_reset ? 1 : 0;
    pulses = 0; lock_edge = -1; err_edge = -1; gap_bad = 0; last = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (serdes_reset) rst_cyc++;
      if (bitslip) begin
        pulses++;
        // five idle cycles between consecutive pulses
        if (last >= 0 && (i - last) != 6) gap_bad++;
        last = i;
      end
      if (aligned && lock_edge < 0) lock_edge = i;
      if (align_error && err_edge < 0) err_edge = i;
      if (aligned || align_error) break;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " serdes_reset"}, 64'(serdes_reset), 64'd1);
    chk({tag, " bitslip"}, 64'(bitslip), 64'd0);
    chk({tag, " aligned"}, 64'(aligned), 64'd0);
    chk({tag, " align_error"}, 64'(align_error), 64'd0);
    chk({tag, " slip_count"}, 64'(slip_count), 64'd0);
    chk({tag, " data_valid"}, 64'(data_valid), 64'd0);
    chk({tag, " adc_data"}, 64'(adc_data), 64'd0);
    chk({tag, " sample_count"}, 64'(sample_count), 64'd0);
  endtask

  initial begin
    int rc, pc, le, ee, gb, held;
    bit seen;

    vecs[0] = '{1'b1, 14'h2000, 14'h0000, 32'hE000_0000};
    vecs[1] = '{1'b0, 14'h2000, 14'h0000, 32'h0000_2000};
    vecs[2] = '{1'b1, 14'h3FFF, 14'h0000, 32'hE000_1FFF};
    vecs[3] = '{1'b1, 14'h1FFF, 14'h3FFF, 32'h1FFF_FFFF};
    vecs[4] = '{1'b0, 14'h3FFF, 14'h1234, 32'h1234_3FFF};
    vecs[5] = '{1'b1, 14'h0001, 14'h2ABC, 32'h0ABC_E001};

    train_start = 1'b0; fmt_twos = 1'b0; frame_word = FR; ch_word = '0;
    reset_async = 1'b0;
    #1 reset_async = 1'b1;
    #1 chk_reset_outputs("por");
    tick();
    reset_async = 1'b0;

    // Cold start, frame already aligned
    train_watch(60, rc, pc, le, ee, gb);
    chk("cold serdes_reset cycles", 64'(rc), 64'd16);
    chk("cold bitslip pulses", 64'(pc), 64'd0);
    chk("cold aligned edge", 64'(le), 64'd21);
    tick();
    chk("cold data_valid edge22", 64'(data_valid), 64'd1);
    for (int i = 0; i < 10; i++) tick();
    chk("cold sample_count", 64'(sample_count), 64'd10);

    // Formatting table, applied while locked
    foreach (vecs[i]) begin
      fmt_twos = vecs[i].twos;
      ch_word  = {vecs[i].c1, vecs[i].c0};
      tick();
      chk($sformatf("fmt vec%0d adc_data", i), 64'(adc_data), 64'(vecs[i].exp));
      chk($sformatf("fmt vec%0d data_valid", i), 64'(data_valid), 64'd1);
    end

    // Three mismatches then a match: lock held, valid drops for exactly those cycles
    for (int i = 0; i < 3; i++) begin
      frame_word = 8'h00;
      tick();
      chk($sformatf("miss%0d aligned", i), 64'(aligned), 64'd1);
      chk($sformatf("miss%0d data_valid", i), 64'(data_valid), 64'd0);
    end
    frame_word = FR;
    tick();
    chk("miss recover data_valid", 64'(data_valid), 64'd1);
    chk("miss recover aligned", 64'(aligned), 64'd1);
    frame_word = 8'h00;
    for (int i = 0; i < 3; i++) tick();
    chk("loss 3rd aligned", 64'(aligned), 64'd1);
    tick();
    chk("loss 4th aligned", 64'(aligned), 64'd0);
    chk("loss 4th serdes_reset", 64'(serdes_reset), 64'd1);
    chk("loss 4th sample_count", 64'(sample_count), 64'd0);
    frame_word = FR;
    train_watch(60, rc, pc, le, ee, gb);
    chk("relock serdes_reset cycles", 64'(rc), 64'd16);
    chk("relock aligned edge", 64'(le), 64'd21);

    // Three-slip training through the deserialiser model
    model_en = 1'b1; model_slips = 0; frame_word = rotl(FR, 3);
    pulse_train();
    train_watch(120, rc, pc, le, ee, gb);
    chk("slip3 pulses", 64'(pc), 64'd3);
    chk("slip3 pulse spacing", 64'(gb), 64'd0);
    chk("slip3 slip_count", 64'(slip_count), 64'd3);
    chk("slip3 aligned edge", 64'(le), 64'd39);
    model_en = 1'b0;

    // Stuck frame: exhaust slips and fail
    frame_word = 8'h00;
    pulse_train();
    train_watch(200, rc, pc, le, ee, gb);
    chk("fail pulses", 64'(pc), 64'd8);
    chk("fail error edge", 64'(ee), 64'd69);
    chk("fail slip_count", 64'(slip_count), 64'd8);
    chk("fail aligned", 64'(aligned), 64'd0);
    held = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (align_error && !aligned && slip_count == 4'd8 && !bitslip) held++;
    end
    chk("fail held 100", 64'(held), 64'd100);
    frame_word = FR;
    pulse_train();
    chk("fail clear align_error", 64'(align_error), 64'd0);
    chk("fail clear slip_count", 64'(slip_count), 64'd0);
    train_watch(60, rc, pc, le, ee, gb);
    chk("fail retrain serdes_reset cycles", 64'(rc), 64'd16);
    chk("fail retrain aligned edge", 64'(le), 64'd21);

    // Async reset mid-SLIP
    frame_word = 8'h00;
    pulse_train();
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = bitslip;
    end
    chk("slip reached", 64'(seen), 64'd1);
    #1 reset_async = 1'b1;
    #1 chk_reset_outputs("rst mid-slip");
    tick();
    reset_async = 1'b0; frame_word = FR; ch_word = {14'h1234, 14'h0567}; fmt_twos = 1'b0;
    train_watch(60, rc, pc, le, ee, gb);
    chk("post-rst aligned edge", 64'(le), 64'd21);
    for (int i = 0; i < 5; i++) tick();
    chk("pre-rst locked adc", 64'(adc_data), 64'h1234_0567);
    #1 reset_async = 1'b1;
    #1 chk_reset_outputs("rst mid-locked");
    tick();
    reset_async = 1'b0;
    train_watch(60, rc, pc, le, ee, gb);
    chk("post-rst2 aligned edge", 64'(le), 64'd21);
    for (int i = 0; i < 4; i++) tick();

    // train_start coincident with the 4th lock-loss mismatch
    frame_word = 8'h00;
    for (int i = 0; i < 3; i++) tick();
    train_start = 1'b1;
    tick();
    train_start = 1'b0;
    chk("coinc aligned", 64'(aligned), 64'd0);
    chk("coinc sample_count", 64'(sample_count), 64'd0);
    frame_word = FR;
    train_watch(60, rc, pc, le, ee, gb);
    chk("coinc serdes_reset cycles", 64'(rc), 64'd16);
    chk("coinc aligned edge", 64'(le), 64'd21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
